reg_write_ctrl: RTL and testbench
=================================

# reg_write_ctrl

Write-side controller for the 16x16 general register file. It reserves destination registers at issue and accepts results from execute/memory with a valid/ready handshake. Results are buffered in a small FIFO and drained one per cycle onto the register file write port (`W_ON`/`WADDR`/`DATA_IN`). Per-register pending bits are exposed to decode for RAW/WAW stalls.

## Interface
- `word_size`, default 16: data width.
- `addr_size`, default 4: register address width; the block tracks 2^addr_size registers.
- `depth`, default 4: result FIFO entries; must be a power of two and at least 2.

- `CLK`  in  1  clock; all state updates on posedge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `ISSUE_VALID`  in  1  decode reserves destination `ISSUE_ADDR`.
- `ISSUE_ADDR`  in  addr_size  destination register to reserve.
- `ISSUE_READY`  out  1  combinational, equals `!pending[ISSUE_ADDR]`.
- `RES_VALID`  in  1  result available.
- `RES_ADDR`  in  addr_size  result destination.
- `RES_DATA`  in  word_size  result value.
- `RES_READY`  out  1  equals `!full`.
- `W_ON`  out  1  register file write enable (registered).
- `WADDR`  out  addr_size  register file write address (registered).
- `DATA_IN`  out  word_size  register file write data (registered).
- `CHK_ADDR1`, `CHK_ADDR2`  in  addr_size  source registers being decoded.
- `CHK_BUSY1`, `CHK_BUSY2`  out  1  combinational, `pending[CHK_ADDRn]`.
- `ERR`  out  1  sticky; set when a result is accepted for a non-pending register.

## Operation
- State:
  - `pending[2^addr_size]` bit vector.
  - FIFO: `depth` entries of {addr, data}, with `wr_ptr`, `rd_ptr` and `count` (width log2(depth)+1).
  - Output registers `W_ON`, `WADDR`, `DATA_IN`.
  - `ERR` flag.
- Issue:
  - Handshake completes on `ISSUE_VALID && ISSUE_READY` at a posedge.
  - The completed handshake sets `pending[ISSUE_ADDR]`.
  - A second issue to an already pending register stalls (WAW).
- Accept:
  - Handshake completes on `RES_VALID && RES_READY` at a posedge.
  - The completed handshake pushes {`RES_ADDR`, `RES_DATA`} at `wr_ptr`.
  - If `pending[RES_ADDR]` is 0 at accept, `ERR` is set to 1 and the entry is still queued and written.
- Drain: at each posedge, if `count != 0`:
  - Pop the head into `WADDR`/`DATA_IN` and set `W_ON`=1.
  - Clear `pending[head addr]`.
  - If `count == 0`, `W_ON`=0; `WADDR`/`DATA_IN` hold their values.
- Push and pop may occur on the same edge; `count` is then unchanged.
- Pointers wrap modulo `depth`. Full is `count==depth`; empty is `count==0`.
- Set and clear of the same pending bit on the same edge cannot occur: issue requires the bit to be clear, and drain only targets set bits when the protocol is respected. If both occur anyway (ERR case), clear wins.
- The block itself never writes the same register twice out of order; FIFO order equals acceptance order.

## Timing
- Reset (`RST_N`=0, asynchronous) takes effect immediately, including mid-operation:
  - `W_ON`=0, `WADDR`=0, `DATA_IN`=0, `ERR`=0.
  - All pending bits 0.
  - FIFO emptied: pointers 0, `count`=0.
  - Queued results are discarded.
- Reset value of every output:
  - `W_ON`=0, `WADDR`=0, `DATA_IN`=0, `ERR`=0.
  - `RES_READY`=1, `ISSUE_READY`=1, `CHK_BUSY1`/`CHK_BUSY2`=0.
- Latency, for a result accepted at edge E0 into an empty FIFO:
  - At E1: `W_ON`=1 with that addr/data, and the pending bit is cleared (`CHK_BUSY` low from E1).
  - The register file latches it on the negedge between E1 and E2.
  - Decode reading at E2 sees the new value.
- Throughput: one write per cycle sustained. With a continuous input stream, `count` stays at 1 and `RES_READY` stays high.
- `W_ON` is high for exactly one cycle per accepted result. Back-to-back results give consecutive `W_ON` cycles.
- Outputs change only on posedge, so they are stable at the register file's negedge write.

## Test plan
- Reset, then drive `RES_READY`/`ISSUE_READY` with no traffic:
  - `RES_READY`=1, `ISSUE_READY`=1, `W_ON`=0, `CHK_BUSY*`=0, `ERR`=0.
- Issue reg 3 at E0, then result {3, 16'hBEEF} at E2:
  - `CHK_BUSY1` (CHK_ADDR1=3) is 1 from E1.
  - At E3: `W_ON`=1, `WADDR`=3, `DATA_IN`=16'hBEEF, busy=0.
  - At E4: `W_ON`=0.
- WAW stall:
  - Issue reg 5, then hold `ISSUE_VALID` with `ISSUE_ADDR`=5.
  - `ISSUE_READY`=0 until the result for 5 drains.
  - The second issue completes the edge after `W_ON`=1 for reg 5.
- FIFO full:
  - Issue regs 1-5.
  - Hold the drain by presenting 5 results on the cycle after reset, with a `depth`=4 build forced full via a test-only stall.
  - Alternatively, with no stall, push 5 results back-to-back and check `RES_READY` never drops and `W_ON` pulses 5 consecutive cycles with addrs 1..5 in order.
- ERR:
  - Accept result {7, 16'h0001} with reg 7 not pending.
  - `ERR`=1 from the next edge and stays 1.
  - The write still occurs: `W_ON`=1, `WADDR`=7.
- Reset mid-operation:
  - Queue 3 results, assert `RST_N`=0 between edges.
  - `W_ON` drops to 0 immediately.
  - After release, no writes occur, and all busy and `ERR` outputs are 0.

Source files
------------

// File: rtl/reg_write_ctrl.sv
// reg_write_ctrl: reserves destination registers at issue and drains buffered results onto the register file write port
module reg_write_ctrl #(
  parameter int word_size = 16,
  parameter int addr_size = 4,
  parameter int depth     = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ISSUE_VALID,
  input  logic [addr_size-1:0] ISSUE_ADDR,
  output logic                 ISSUE_READY,
  input  logic                 RES_VALID,
  input  logic [addr_size-1:0] RES_ADDR,
  input  logic [word_size-1:0] RES_DATA,
  output logic                 RES_READY,
  output logic                 W_ON,
  output logic [addr_size-1:0] WADDR,
  output logic [word_size-1:0] DATA_IN,
  input  logic [addr_size-1:0] CHK_ADDR1,
  input  logic [addr_size-1:0] CHK_ADDR2,
  output logic                 CHK_BUSY1,
  output logic                 CHK_BUSY2,
  output logic                 ERR
);
  localparam int nregs = 1 << addr_size;
  localparam int pw = $clog2(depth);
  localparam int cw = pw + 1;
  logic [nregs-1:0]                 pending_q, pending_d;
  logic [depth-1:0][addr_size-1:0]  fifo_addr_q, fifo_addr_d;
  logic [depth-1:0][word_size-1:0]  fifo_data_q, fifo_data_d;
  logic [pw-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cw-1:0]                    count_q, count_d;
  logic                             w_on_q, w_on_d, err_q, err_d;
  logic [addr_size-1:0]             waddr_q, waddr_d;
  logic [word_size-1:0]             data_in_q, data_in_d;
  logic                             issue_fire, push, pop;
  assign ISSUE_READY = !pending_q[ISSUE_ADDR];
  assign RES_READY   = count_q != cw'(depth);
  assign CHK_BUSY1   = pending_q[CHK_ADDR1];
  assign CHK_BUSY2   = pending_q[CHK_ADDR2];
  assign W_ON        = w_on_q;
  assign WADDR       = waddr_q;
  assign DATA_IN     = data_in_q;
  assign ERR         = err_q;
  always_comb begin
    issue_fire  = ISSUE_VALID && ISSUE_READY;
    push        = RES_VALID && RES_READY;
    pop         = count_q != '0;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = RES_ADDR;
      fifo_data_d[wr_ptr_q] = RES_DATA;
    end
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + {{pw{1'b0}}, push} - {{pw{1'b0}}, pop};
    w_on_d    = pop;
    waddr_d   = pop ? fifo_addr_q[rd_ptr_q] : waddr_q;
    data_in_d = pop ? fifo_data_q[rd_ptr_q] : data_in_q;
    err_d     = err_q || (push && !pending_q[RES_ADDR]);
    pending_d = pending_q;
    if (issue_fire) pending_d[ISSUE_ADDR] = 1'b1;
    // clear after set so a drain wins over a coincident issue
    if (pop) pending_d[fifo_addr_q[rd_ptr_q]] = 1'b0;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_q   <= '0;
      fifo_addr_q <= '0;
      fifo_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      w_on_q      <= 1'b0;
      waddr_q     <= '0;
      data_in_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      w_on_q      <= w_on_d;
      waddr_q     <= waddr_d;
      data_in_q   <= data_in_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_reg_write_ctrl.sv
// tb_reg_write_ctrl: directed and random stimulus checked against a queue-based reference model
module tb_reg_write_ctrl;
  localparam int dp = 4;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        ISSUE_VALID = 1'b0, RES_VALID = 1'b0;
  logic [3:0]  ISSUE_ADDR = '0, RES_ADDR = '0, CHK_ADDR1 = '0, CHK_ADDR2 = '0;
  logic [15:0] RES_DATA = '0;
  logic        ISSUE_READY, RES_READY, W_ON, CHK_BUSY1, CHK_BUSY2, ERR;
  logic [3:0]  WADDR;
  logic [15:0] DATA_IN;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic [3:0] a; logic [15:0] d;} ent_t;
  ent_t        q[$];
  logic [15:0] m_pend;
  logic        m_won, m_err;
  logic [3:0]  m_waddr;
  logic [15:0] m_data;

  reg_write_ctrl #(.word_size(16), .addr_size(4), .depth(dp)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_ADDR(ISSUE_ADDR), .ISSUE_READY(ISSUE_READY),
    .RES_VALID(RES_VALID), .RES_ADDR(RES_ADDR), .RES_DATA(RES_DATA), .RES_READY(RES_READY),
    .W_ON(W_ON), .WADDR(WADDR), .DATA_IN(DATA_IN),
    .CHK_ADDR1(CHK_ADDR1), .CHK_ADDR2(CHK_ADDR2), .CHK_BUSY1(CHK_BUSY1), .CHK_BUSY2(CHK_BUSY2),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    q.delete();
    m_won = 1'b0;
    m_waddr = '0;
    m_data = '0;
    m_err = 1'b0;
  endtask

  // one clock: check combinational outputs, advance the model, check registered outputs
  task automatic step();
    ent_t e;
    logic [15:0] np;
    logic acc, iss;
    #1;
    chk("issue_ready", ISSUE_READY, !m_pend[ISSUE_ADDR]);
    chk("res_ready", RES_READY, q.size() < dp);
    chk("chk_busy1", CHK_BUSY1, m_pend[CHK_ADDR1]);
    chk("chk_busy2", CHK_BUSY2, m_pend[CHK_ADDR2]);
    iss = ISSUE_VALID && !m_pend[ISSUE_ADDR];
    acc = RES_VALID && q.size() < dp;
    np = m_pend;
    if (iss) np[ISSUE_ADDR] = 1'b1;
    if (q.size() != 0) begin
      e = q.pop_front();
      m_won = 1'b1;
      m_waddr = e.a;
      m_data = e.d;
      np[e.a] = 1'b0;
    end else m_won = 1'b0;
    if (acc) begin
      if (!m_pend[RES_ADDR]) m_err = 1'b1;
      q.push_back({RES_ADDR, RES_DATA});
    end
    m_pend = np;
    @(posedge CLK);
    #1;
    chk("w_on", W_ON, m_won);
    chk("waddr", WADDR, m_waddr);
    chk("data_in", DATA_IN, m_data);
    chk("err", ERR, m_err);
    @(negedge CLK);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_w_on", W_ON, 0);
    chk("rst_waddr", WADDR, 0);
    chk("rst_data_in", DATA_IN, 0);
    chk("rst_err", ERR, 0);
    chk("rst_res_ready", RES_READY, 1);
    chk("rst_issue_ready", ISSUE_READY, 1);
    chk("rst_busy1", CHK_BUSY1, 0);
    chk("rst_busy2", CHK_BUSY2, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    // issue reg 3, result BEEF two cycles later
    CHK_ADDR1 = 4'd3;
    ISSUE_VALID = 1'b1; ISSUE_ADDR = 4'd3;
    step();
    ISSUE_VALID = 1'b0;
    chk("busy_after_issue", CHK_BUSY1, 1);
    step();
    RES_VALID = 1'b1; RES_ADDR = 4'd3; RES_DATA = 16'hBEEF;
    step();
    RES_VALID = 1'b0;
    step();
    chk("beef_w_on", W_ON, 1);
    chk("beef_waddr", WADDR, 3);
    chk("beef_data", DATA_IN, 16'hBEEF);
    chk("beef_busy", CHK_BUSY1, 0);
    step();
    chk("beef_w_on_off", W_ON, 0);
    // WAW stall on reg 5
    CHK_ADDR1 = 4'd5;
    ISSUE_VALID = 1'b1; ISSUE_ADDR = 4'd5;
    step();
    chk("waw_stall", ISSUE_READY, 0);
    step();
    RES_VALID = 1'b1; RES_ADDR = 4'd5; RES_DATA = 16'h1234;
    step();
    RES_VALID = 1'b0;
    chk("waw_still_stalled", ISSUE_READY, 0);
    step();
    chk("waw_drain", W_ON, 1);
    chk("waw_ready", ISSUE_READY, 1);
    step();
    ISSUE_VALID = 1'b0;
    chk("waw_reissued", CHK_BUSY1, 1);
    RES_VALID = 1'b1; RES_ADDR = 4'd5; RES_DATA = 16'h5555;
    step();
    RES_VALID = 1'b0;
    step();
    // five back-to-back results to regs 1..5
    for (int i = 1; i <= 5; i++) begin
      ISSUE_VALID = 1'b1; ISSUE_ADDR = 4'(i);
      step();
    end
    ISSUE_VALID = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      RES_VALID = i <= 5;
      RES_ADDR = 4'(i);
      RES_DATA = 16'($urandom);
      chk("b2b_res_ready", RES_READY, 1);
      step();
      if (i >= 2) begin
        chk("b2b_w_on", W_ON, 1);
        chk("b2b_waddr", WADDR, i - 1);
      end
    end
    RES_VALID = 1'b0;
    step();
    // result for a register that was never issued
    RES_VALID = 1'b1; RES_ADDR = 4'd7; RES_DATA = 16'h0001;
    step();
    RES_VALID = 1'b0;
    chk("err_set", ERR, 1);
    step();
    chk("err_w_on", W_ON, 1);
    chk("err_waddr", WADDR, 7);
    step();
    step();
    chk("err_sticky", ERR, 1);
    // reset with results in flight
    for (int i = 8; i <= 10; i++) begin
      RES_VALID = 1'b1; RES_ADDR = 4'(i); RES_DATA = 16'(i);
      step();
    end
    RES_VALID = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst_w_on", W_ON, 0);
    chk("midrst_err", ERR, 0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_w_on", W_ON, 0);
    end
    // random traffic with one reset partway through
    for (int i = 0; i < 400; i++) begin
      ISSUE_VALID = 1'($urandom);
      ISSUE_ADDR = 4'($urandom);
      RES_VALID = ($urandom % 3) == 0;
      RES_ADDR = 4'($urandom);
      RES_DATA = 16'($urandom);
      CHK_ADDR1 = 4'($urandom);
      CHK_ADDR2 = 4'($urandom);
      if (i == 200) begin
        RST_N = 1'b0;
        #1;
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
